// File: rtl/hazard_ctrl.sv
// Hazard, stall and flush control for the RV32I 5-stage pipeline.
// Also provides EX operand forwarding selects and saturating perf counters.
module hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rs1_addr,
    input  logic [4:0]       ex_rs2_addr,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_rd_wren,
    input  logic             ex_is_load,
    input  logic [4:0]       mem_rd_addr,
    input  logic             mem_rd_wren,
    input  logic [4:0]       wb_rd_addr,
    input  logic             wb_rd_wren,
    input  logic             ex_br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_clr,
    output logic             id_ex_en,
    output logic             id_ex_clr,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    typedef enum logic [1:0] {RUN, LDUSE, MEMWAIT} state_t;

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT);

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          freeze, flush, lduse, ld_hit;

    function automatic logic [1:0] fwd_pick(
        input logic [4:0] rs,
        input logic [4:0] mrd,
        input logic       mwr,
        input logic [4:0] wrd,
        input logic       wwr
    );
        if (mwr && mrd != 5'd0 && mrd == rs) return 2'b01;
        if (wwr && wrd != 5'd0 && wrd == rs) return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        freeze = dmem_req & ~dmem_ready;
        ld_hit = ex_is_load & ex_rd_wren & (ex_rd_addr != 5'd0) &
                 ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                  (id_rs2_used & (id_rs2_addr == ex_rd_addr)));
        flush  = ~freeze & ex_br_taken;
        lduse  = ~freeze & ~ex_br_taken & ld_hit;

        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        if_id_clr = 1'b0;
        id_ex_en  = 1'b1;
        id_ex_clr = 1'b0;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        state_nxt = RUN;

        unique case (1'b1)
            freeze: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
                state_nxt = MEMWAIT;
            end
            flush: begin
                if_id_clr = 1'b1;
                id_ex_clr = 1'b1;
            end
            lduse: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_clr = 1'b1;
                state_nxt = LDUSE;
            end
            default: ;
        endcase

        fwd_a_sel = fwd_pick(ex_rs1_addr, mem_rd_addr, mem_rd_wren,
                             wb_rd_addr, wb_rd_wren);
        fwd_b_sel = fwd_pick(ex_rs2_addr, mem_rd_addr, mem_rd_wren,
                             wb_rd_addr, wb_rd_wren);

        // Held in reset: everything disabled, bubbles injected.
        if (!rst_ni) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            if_id_clr = 1'b1;
            id_ex_en  = 1'b0;
            id_ex_clr = 1'b1;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            fwd_a_sel = 2'b00;
            fwd_b_sel = 2'b00;
        end

        // A fresh wait episode starts at 1; otherwise count up and saturate.
        if (!freeze)
            wait_nxt = '0;
        else if (state != MEMWAIT)
            wait_nxt = WW'(1);
        else if (wait_cnt == WMAX)
            wait_nxt = wait_cnt;
        else
            wait_nxt = wait_cnt + WW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (freeze && wait_nxt == WMAX)
                mem_err <= 1'b1;
            if ((freeze || lduse) && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_ctrl;

    localparam int CW = 4;
    localparam int TO = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs1, id_rs2;
        logic       id_u1, id_u2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_wr, ex_ld;
        logic [4:0] mem_rd;
        logic       mem_wr;
        logic [4:0] wb_rd;
        logic       wb_wr;
        logic       br, req, rdy;
    } stim_t;

    typedef struct packed {
        logic [6:0]    ctrl;
        logic [1:0]    fa, fb;
        logic [CW-1:0] st, fl;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic [4:0] id_rs1_addr = 0, id_rs2_addr = 0;
    logic id_rs1_used = 0, id_rs2_used = 0;
    logic [4:0] ex_rs1_addr = 0, ex_rs2_addr = 0, ex_rd_addr = 0;
    logic ex_rd_wren = 0, ex_is_load = 0;
    logic [4:0] mem_rd_addr = 0, wb_rd_addr = 0;
    logic mem_rd_wren = 0, wb_rd_wren = 0;
    logic ex_br_taken = 0, dmem_req = 0, dmem_ready = 1;
    logic pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr;
    logic ex_mem_en, mem_wb_en, mem_err;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_rd_addr(ex_rd_addr), .ex_rd_wren(ex_rd_wren),
        .ex_is_load(ex_is_load),
        .mem_rd_addr(mem_rd_addr), .mem_rd_wren(mem_rd_wren),
        .wb_rd_addr(wb_rd_addr), .wb_rd_wren(wb_rd_wren),
        .ex_br_taken(ex_br_taken), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_clr(if_id_clr),
        .id_ex_en(id_ex_en), .id_ex_clr(id_ex_clr),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_stall = 0, m_flush = 0, m_run = 0;
    bit   m_err   = 0;
    int   hold    = 0;
    localparam int CMAX = (1 << CW) - 1;

    // Reference: per-cycle action chosen by priority, counters as integers.
    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        bit fz, hit;
        fz  = s.req && !s.rdy;
        hit = s.ex_ld && s.ex_wr && s.ex_rd != 0 &&
              ((s.id_u1 && s.id_rs1 == s.ex_rd) ||
               (s.id_u2 && s.id_rs2 == s.ex_rd));
        if (!s.rst)    e.ctrl = 7'b0010100;
        else if (fz)   e.ctrl = 7'b0000000;
        else if (s.br) e.ctrl = 7'b1111111;
        else if (hit)  e.ctrl = 7'b0001111;
        else           e.ctrl = 7'b1101011;
        e.fa = 2'b00;
        e.fb = 2'b00;
        if (s.rst) begin
            if (s.mem_wr && s.mem_rd != 0 && s.mem_rd == s.ex_rs1) e.fa = 2'b01;
            else if (s.wb_wr && s.wb_rd != 0 && s.wb_rd == s.ex_rs1) e.fa = 2'b10;
            if (s.mem_wr && s.mem_rd != 0 && s.mem_rd == s.ex_rs2) e.fb = 2'b01;
            else if (s.wb_wr && s.wb_rd != 0 && s.wb_rd == s.ex_rs2) e.fb = 2'b10;
        end
        e.st  = s.rst ? CW'(m_stall) : '0;
        e.fl  = s.rst ? CW'(m_flush) : '0;
        e.err = s.rst ? m_err : 1'b0;
        return e;
    endfunction

    task automatic model_edge(input stim_t s, input exp_t e);
        if (!s.rst) begin
            m_stall = 0; m_flush = 0; m_run = 0; m_err = 0;
        end else if (e.ctrl == 7'b0000000) begin
            if (m_stall < CMAX) m_stall++;
            if (m_run < TO) m_run++;
            if (m_run >= TO) m_err = 1;
        end else begin
            m_run = 0;
            if (e.ctrl == 7'b1111111 && m_flush < CMAX) m_flush++;
            if (e.ctrl == 7'b0001111 && m_stall < CMAX) m_stall++;
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst_ni = s.rst;
        id_rs1_addr = s.id_rs1; id_rs2_addr = s.id_rs2;
        id_rs1_used = s.id_u1;  id_rs2_used = s.id_u2;
        ex_rs1_addr = s.ex_rs1; ex_rs2_addr = s.ex_rs2;
        ex_rd_addr = s.ex_rd;   ex_rd_wren = s.ex_wr;
        ex_is_load = s.ex_ld;
        mem_rd_addr = s.mem_rd; mem_rd_wren = s.mem_wr;
        wb_rd_addr = s.wb_rd;   wb_rd_wren = s.wb_wr;
        ex_br_taken = s.br; dmem_req = s.req; dmem_ready = s.rdy;
        e = model_out(s);
        q.push_back(e);
        model_edge(s, e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ctrl", {pc_en, if_id_en, if_id_clr, id_ex_en,
                             id_ex_clr, ex_mem_en, mem_wb_en}, e.ctrl);
                chk("fwd_a", fwd_a_sel, e.fa);
                chk("fwd_b", fwd_b_sel, e.fb);
                chk("stall_cnt", stall_cnt, e.st);
                chk("flush_cnt", flush_cnt, e.fl);
                chk("mem_err", mem_err, e.err);
            end
        end
    end

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst = 1'b1;
        s.rdy = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst    = ($urandom_range(0, 99) != 0);
        s.id_rs1 = 5'($urandom_range(0, 3));
        s.id_rs2 = 5'($urandom_range(0, 3));
        s.id_u1  = 1'($urandom);
        s.id_u2  = 1'($urandom);
        s.ex_rs1 = 5'($urandom_range(0, 3));
        s.ex_rs2 = 5'($urandom_range(0, 3));
        s.ex_rd  = 5'($urandom_range(0, 3));
        s.ex_wr  = 1'($urandom);
        s.ex_ld  = 1'($urandom);
        s.mem_rd = 5'($urandom_range(0, 3));
        s.mem_wr = 1'($urandom);
        s.wb_rd  = 5'($urandom_range(0, 3));
        s.wb_wr  = 1'($urandom);
        s.br     = ($urandom_range(0, 5) == 0);
        if (hold > 0) begin
            hold--;
            s.req = 1'b1;
            s.rdy = 1'b0;
        end else begin
            if ($urandom_range(0, 29) == 0) hold = $urandom_range(3, 6);
            s.req = 1'($urandom);
            s.rdy = ($urandom_range(0, 2) != 0);
        end
        return s;
    endfunction

    initial begin : driver
        stim_t s, r;
        r = idle();
        r.rst = 1'b0;
        step(r);
        step(r);
        // load-use on x5, then the bubble, then WB forwarding
        s = idle();
        s.ex_ld = 1; s.ex_wr = 1; s.ex_rd = 5;
        s.id_rs1 = 5; s.id_u1 = 1; s.id_rs2 = 1; s.id_u2 = 1;
        step(s);
        s = idle(); s.mem_rd = 5; s.mem_wr = 1;
        step(s);
        s = idle(); s.ex_rs1 = 5; s.ex_rs2 = 1; s.wb_rd = 5; s.wb_wr = 1;
        step(s);
        // load to x0: no stall, no forwarding of x0
        s = idle();
        s.ex_ld = 1; s.ex_wr = 1; s.id_u1 = 1; s.id_u2 = 1;
        s.mem_wr = 1; s.wb_wr = 1;
        step(s);
        step(r);
        // branch beats load-use
        s = idle();
        s.ex_ld = 1; s.ex_wr = 1; s.ex_rd = 3; s.id_rs2 = 3; s.id_u2 = 1;
        s.br = 1;
        step(s);
        step(idle());
        step(r);
        // branch held through a 3-cycle freeze
        s = idle(); s.br = 1; s.req = 1; s.rdy = 0;
        repeat (3) step(s);
        s.rdy = 1;
        step(s);
        step(idle());
        // dmem timeout, then sticky error
        s = idle(); s.req = 1; s.rdy = 0;
        repeat (6) step(s);
        s.rdy = 1;
        step(s);
        step(idle());
        step(idle());
        // MEM beats WB on rs2, then WB alone
        s = idle();
        s.ex_rs2 = 7; s.ex_rs1 = 7; s.mem_rd = 7; s.mem_wr = 1;
        s.wb_rd = 7; s.wb_wr = 1;
        step(s);
        s.mem_wr = 0;
        step(s);
        // reset asserted in the middle of a freeze
        s = idle(); s.req = 1; s.rdy = 0; s.br = 1;
        step(s);
        step(s);
        s.rst = 0;
        step(s);
        step(idle());
        // saturate the stall counter
        s = idle(); s.ex_ld = 1; s.ex_wr = 1; s.ex_rd = 2;
        s.id_rs1 = 2; s.id_u1 = 1;
        repeat (CMAX + 3) step(s);
        repeat (CMAX + 3) begin
            s = idle(); s.br = 1;
            step(s);
        end
        for (int i = 0; i < 3000; i++) step(rnd());
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
